// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch front end: redirect kinds,
// fetch sequencer states and default vectors.
package mips_pkg;

    localparam logic [31:0] DEF_RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] DEF_EXC_VECTOR = 32'h0000_0180;

    typedef enum logic [1:0] {
        REDIR_BRANCH = 2'd0,
        REDIR_JUMP   = 2'd1,
        REDIR_JR     = 2'd2,
        REDIR_EXC    = 2'd3
    } redir_kind_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/pc_target_calc.sv
// Combinational redirect target generator for branch, jump, jump-register
// and exception redirects.
module pc_target_calc
    import mips_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
    input  logic [1:0]  redir_kind,
    input  logic [31:0] redir_pc,
    input  logic [25:0] redir_imm,
    input  logic [31:0] redir_reg,
    output logic [31:0] target,
    output logic        misaligned
);

    logic [31:0] seq_pc;

    assign seq_pc = redir_pc + 32'd4;

    // Select the target by redirect kind; misaligned JR falls back to the exception vector.
    always_comb begin
        target     = EXC_VECTOR;
        misaligned = 1'b0;
        case (redir_kind_e'(redir_kind))
            REDIR_BRANCH: target = seq_pc + {{14{redir_imm[15]}}, redir_imm[15:0], 2'b00};
            REDIR_JUMP:   target = {seq_pc[31:28], redir_imm, 2'b00};
            REDIR_JR: begin
                if (redir_reg[1:0] == 2'b00) begin
                    target = redir_reg;
                end else begin
                    misaligned = 1'b1;
                end
            end
            default:      target = EXC_VECTOR;
        endcase
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch sequencer: owns the PC, runs the instruction-memory handshake,
// holds the fetched word for decode and applies control-flow redirects.
module pc_fetch_ctrl
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
    parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    input  logic        redir_valid,
    input  logic [1:0]  redir_kind,
    input  logic [31:0] redir_pc,
    input  logic [25:0] redir_imm,
    input  logic [31:0] redir_reg,
    output logic        addr_err,
    output logic [31:0] pc
);

    fetch_state_e state, state_d;
    logic [31:0]  pc_d, pend_pc, pend_pc_d, instr_d, instr_pc_d;
    logic         kill, kill_d, addr_err_d;
    logic [31:0]  target;
    logic         misaligned;

    pc_target_calc #(
        .EXC_VECTOR (EXC_VECTOR)
    ) u_target (
        .redir_kind (redir_kind),
        .redir_pc   (redir_pc),
        .redir_imm  (redir_imm),
        .redir_reg  (redir_reg),
        .target     (target),
        .misaligned (misaligned)
    );

    // State, PC, pending-redirect and hold registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            pc       <= RESET_PC;
            pend_pc  <= RESET_PC;
            kill     <= 1'b0;
            instr    <= '0;
            instr_pc <= '0;
            addr_err <= 1'b0;
        end else begin
            state    <= state_d;
            pc       <= pc_d;
            pend_pc  <= pend_pc_d;
            kill     <= kill_d;
            instr    <= instr_d;
            instr_pc <= instr_pc_d;
            addr_err <= addr_err_d;
        end
    end

    // Next-state and outputs. While a request is outstanding the PC (and so
    // imem_addr) is frozen; a redirect is parked in pend_pc and the response
    // is discarded via kill.
    always_comb begin
        state_d     = state;
        pc_d        = pc;
        pend_pc_d   = pend_pc;
        kill_d      = kill;
        instr_d     = instr;
        instr_pc_d  = instr_pc;
        addr_err_d  = redir_valid && misaligned;
        imem_req    = (state == ST_FETCH);
        imem_addr   = pc;
        instr_valid = (state == ST_HOLD) && !redir_valid;
        case (state)
            ST_IDLE: begin
                if (redir_valid) pc_d = target;
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (redir_valid) begin
                    if (imem_ready) begin
                        pc_d   = target;
                        kill_d = 1'b0;
                    end else begin
                        pend_pc_d = target;
                        kill_d    = 1'b1;
                    end
                end else if (imem_ready) begin
                    if (kill) begin
                        pc_d   = pend_pc;
                        kill_d = 1'b0;
                    end else begin
                        instr_d    = imem_rdata;
                        instr_pc_d = pc;
                        state_d    = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (redir_valid) begin
                    pc_d    = target;
                    state_d = ST_FETCH;
                end else if (instr_ready) begin
                    pc_d    = pc + 32'd4;
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: directed scenarios followed by
// randomized traffic, all compared against a transaction-level model.
module tb_pc_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        redir_valid;
    logic [1:0]  redir_kind;
    logic [31:0] redir_pc;
    logic [25:0] redir_imm;
    logic [31:0] redir_reg;
    logic        addr_err;
    logic [31:0] pc;

    int checks = 0;
    int errors = 0;

    pc_fetch_ctrl #(
        .RESET_PC   (32'h0000_0000),
        .EXC_VECTOR (32'h0000_0180)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready),
        .redir_valid (redir_valid),
        .redir_kind  (redir_kind),
        .redir_pc    (redir_pc),
        .redir_imm   (redir_imm),
        .redir_reg   (redir_reg),
        .addr_err    (addr_err),
        .pc          (pc)
    );

    always #5 clk = ~clk;

    // Reference model: booleans for "request outstanding" / "word held".
    bit          m_known = 0;
    bit          m_fetching, m_holding, m_killed, m_err;
    logic [31:0] m_pc, m_pend, m_instr, m_ipc;

    function automatic logic [32:0] ref_target(input logic [1:0] k, input logic [31:0] rp,
                                               input logic [25:0] imm, input logic [31:0] rr);
        logic [31:0] off;
        logic [31:0] idx;
        off = {{16{imm[15]}}, imm[15:0]};
        idx = {6'd0, imm};
        case (k)
            2'd0:    return {1'b0, rp + 32'd4 + off * 32'd4};
            2'd1:    return {1'b0, ((rp + 32'd4) & 32'hF000_0000) | (idx * 32'd4)};
            2'd2:    return (rr % 32'd4 == 32'd0) ? {1'b0, rr} : {1'b1, 32'h0000_0180};
            default: return {1'b0, 32'h0000_0180};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_update();
        logic [32:0] t;
        if (reset) begin
            m_known = 1; m_fetching = 0; m_holding = 0; m_killed = 0; m_err = 0;
            m_pc = 32'h0; m_pend = 32'h0; m_instr = 32'h0; m_ipc = 32'h0;
            return;
        end
        t = ref_target(redir_kind, redir_pc, redir_imm, redir_reg);
        m_err = redir_valid && t[32];
        if (!m_fetching && !m_holding) begin
            if (redir_valid) m_pc = t[31:0];
            m_fetching = 1;
        end else if (m_fetching) begin
            if (redir_valid) begin
                if (imem_ready) begin m_pc = t[31:0]; m_killed = 0; end
                else begin m_pend = t[31:0]; m_killed = 1; end
            end else if (imem_ready) begin
                if (m_killed) begin m_pc = m_pend; m_killed = 0; end
                else begin
                    m_instr = imem_rdata; m_ipc = m_pc;
                    m_fetching = 0; m_holding = 1;
                end
            end
        end else begin
            if (redir_valid) begin m_pc = t[31:0]; m_holding = 0; m_fetching = 1; end
            else if (instr_ready) begin m_pc = m_pc + 32'd4; m_holding = 0; m_fetching = 1; end
        end
    endtask

    // One clock: inputs already driven, compare outputs mid-cycle, then advance.
    task automatic step(input string tag);
        imem_rdata = $urandom;
        #1;
        if (m_known) begin
            chk({tag, ":imem_req"},    {31'd0, imem_req},    {31'd0, m_fetching});
            chk({tag, ":imem_addr"},   imem_addr,            m_pc);
            chk({tag, ":pc"},          pc,                   m_pc);
            chk({tag, ":instr_valid"}, {31'd0, instr_valid}, {31'd0, m_holding && !redir_valid});
            chk({tag, ":instr"},       instr,                m_instr);
            chk({tag, ":instr_pc"},    instr_pc,             m_ipc);
            chk({tag, ":addr_err"},    {31'd0, addr_err},    {31'd0, m_err});
        end
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic redir(input logic [1:0] k, input logic [31:0] rp, input logic [25:0] imm,
                         input logic [31:0] rr);
        redir_valid = 1; redir_kind = k; redir_pc = rp; redir_imm = imm; redir_reg = rr;
    endtask

    logic [31:0] addrs[$];

    initial begin
        reset = 1; imem_ready = 1; instr_ready = 1; redir_valid = 0;
        redir_kind = 0; redir_pc = 0; redir_imm = 0; redir_reg = 0; imem_rdata = 0;
        step("reset0");
        step("reset1");
        reset = 0;

        // Streaming with zero-wait memory and decode always ready.
        for (int i = 0; i < 8; i++) begin
            step("stream");
            if (imem_req) addrs.push_back(imem_addr);
        end
        chk("stream_count", addrs.size(), 4);
        for (int i = 0; i < 4 && i < addrs.size(); i++)
            chk("stream_addr", addrs[i], 32'(i * 4));

        // Branch while holding.
        instr_ready = 0;
        for (int n = 0; n < 10 && !instr_valid; n++) step("to_hold");
        chk("reach_hold", {31'd0, instr_valid}, 32'd1);
        redir(2'd0, 32'h100, 26'h000FFFE, 32'h0);
        instr_ready = 1;
        step("branch");
        redir_valid = 0;
        chk("branch_addr", imem_addr, 32'h0000_00FC);
        chk("branch_req", {31'd0, imem_req}, 32'd1);

        // Jump with ready in the same cycle, then misaligned JR.
        redir(2'd1, 32'hF000_0010, 26'h0000040, 32'h0);
        step("jump");
        chk("jump_addr", imem_addr, 32'hF000_0100);
        redir(2'd2, 32'h0, 26'h0, 32'h2002);
        step("jr_bad");
        redir_valid = 0;
        chk("jr_addr", imem_addr, 32'h0000_0180);
        chk("jr_err", {31'd0, addr_err}, 32'd1);
        imem_ready = 0;
        step("jr_after");
        chk("jr_err_pulse", {31'd0, addr_err}, 32'd0);

        // Exception while a request waits on memory.
        redir(2'd2, 32'h0, 26'h0, 32'h200);
        imem_ready = 1;
        step("jr_200");
        redir_valid = 0; imem_ready = 0;
        step("wait1");
        redir(2'd3, 32'h44, 26'h0, 32'h0);
        step("exc_wait");
        redir_valid = 0;
        for (int i = 0; i < 2; i++) begin
            step("wait2");
            chk("exc_addr_stable", imem_addr, 32'h0000_0200);
        end
        imem_ready = 1;
        step("exc_drop");
        chk("exc_new_addr", imem_addr, 32'h0000_0180);
        chk("exc_no_valid", {31'd0, instr_valid}, 32'd0);
        instr_ready = 0;
        step("exc_fetch");
        chk("exc_ipc", instr_pc, 32'h0000_0180);

        // Decode stalls for five cycles.
        for (int i = 0; i < 5; i++) begin
            step("stall");
            chk("stall_req", {31'd0, imem_req}, 32'd0);
            chk("stall_pc", pc, 32'h0000_0180);
        end
        instr_ready = 1;
        step("stall_accept");

        // Reset while a fetch is outstanding.
        redir(2'd2, 32'h0, 26'h0, 32'h40);
        step("jr_40");
        redir_valid = 0; imem_ready = 0;
        step("fetch_40");
        chk("fetch_40_addr", imem_addr, 32'h0000_0040);
        reset = 1;
        step("reset_mid");
        reset = 0;
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);

        // PC wrap-around from the top of the address space.
        redir(2'd2, 32'h0, 26'h0, 32'hFFFF_FFFC);
        step("wrap_idle");
        redir_valid = 0; imem_ready = 1;
        step("wrap_fetch");
        step("wrap_accept");
        chk("wrap_pc", pc, 32'h0);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            reset       = ($urandom % 60) == 0;
            imem_ready  = ($urandom % 3) != 0;
            instr_ready = ($urandom % 3) != 0;
            redir_valid = ($urandom % 6) == 0;
            redir_kind  = 2'($urandom);
            redir_pc    = $urandom;
            redir_imm   = 26'($urandom);
            redir_reg   = $urandom;
            if ($urandom % 2 == 0) redir_reg[1:0] = 2'b00;
            step("random");
        end
        reset = 0; redir_valid = 0;
        step("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_fetch_ctrl.md
# pc_fetch_ctrl

Fetch sequencer owning the MIPS program counter: issues instruction-memory read handshakes, hands fetched words to decode with a valid/ready handshake, and applies control-flow redirects (branch, jump, jump-register, exception) from later stages. It replaces the free-running PC register with a sequenced PC and sits between the instruction memory and the decode stage.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset
- EXC_VECTOR, 32'h0000_0180, target for exceptions and misaligned JR

- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- imem_req  out  1  read request to instruction memory
- imem_addr  out  32  read address; stable while imem_req && !imem_ready
- imem_ready  in  1  read completes this cycle
- imem_rdata  in  32  instruction word, valid when imem_req && imem_ready
- instr_valid  out  1  held instruction available to decode
- instr  out  32  held instruction word
- instr_pc  out  32  address of held instruction
- instr_ready  in  1  decode accepts instruction
- redir_valid  in  1  redirect request this cycle
- redir_kind  in  2  0 BRANCH, 1 JUMP, 2 JR, 3 EXC
- redir_pc  in  32  PC of the redirecting instruction
- redir_imm  in  26  BRANCH uses [15:0]; JUMP uses [25:0]
- redir_reg  in  32  JR target register value
- addr_err  out  1  one-cycle pulse: JR target misaligned
- pc  out  32  current PC register

## Operation
- States: IDLE, FETCH, HOLD. Reset -> IDLE; IDLE -> FETCH unconditionally next cycle.
- FETCH: imem_req=1, imem_addr=pc. On imem_ready (no kill, no redirect): instr<=imem_rdata, instr_pc<=pc, -> HOLD.
- HOLD: instr_valid=1. On instr_valid && instr_ready: pc<=pc+4, -> FETCH.
- Target arithmetic (all mod 2^32): BRANCH = redir_pc+4+(sext(imm[15:0])<<2); JUMP = {(redir_pc+4)[31:28], imm[25:0], 2'b00}; JR = redir_reg if redir_reg[1:0]==0, else EXC_VECTOR with addr_err=1 next cycle; EXC = EXC_VECTOR.
- Redirect in IDLE or HOLD: pc<=target, held instruction dropped, -> FETCH.
- Redirect in FETCH with imem_ready same cycle: response discarded, pc<=target, stay FETCH.
- Redirect in FETCH without imem_ready: imem_addr must not change; pend_pc<=target, kill<=1, stay FETCH. On later imem_ready with kill=1: data discarded, pc<=pend_pc, kill<=0, stay FETCH (new request next cycle).
- Second redirect while kill=1: newest target overwrites pend_pc.
- instr_valid is masked low during any cycle with redir_valid=1; a handshake in that cycle is not a transfer.
- PC wrap: 32'hFFFF_FFFC + 4 = 0, no flag.

## Timing
- Reset values: imem_req 0, imem_addr RESET_PC, pc RESET_PC, instr_valid 0, instr 0, instr_pc 0, addr_err 0, kill 0.
- First imem_req: 2nd cycle after reset deasserts (IDLE occupies one cycle).
- Zero-wait memory: request cycle N, instr_valid N+1, accepted N+1 -> next request N+2; peak 1 instr / 2 cycles.
- Redirect to first request at target: 1 cycle (next cycle) unless a request is outstanding; then 1 cycle after imem_ready.
- Reset mid-transaction: request dropped immediately; imem is required to tolerate an abandoned request.
- addr_err asserted exactly the cycle after the JR redirect.

## Structure
- Shared package mips_pkg: redirect-kind encodings, RESET_PC and EXC_VECTOR defaults, state encoding.
- One combinational sub-module pc_target_calc (redir_kind, redir_pc, redir_imm, redir_reg -> target, misaligned); FSM, PC, pend_pc, kill and hold registers in the top.

## Test plan
- Reset release, imem_ready tied 1, instr_ready tied 1 -> imem_addr sequence 0,4,8,C on alternate cycles, instr_pc matches each.
- BRANCH redir_pc=0x100, imm=0xFFFE in HOLD -> held instruction dropped, next imem_addr=0x0FC.
- JUMP redir_pc=0xF000_0010, imm=0x0000040 -> imem_addr=0xF000_0100; JR redir_reg=0x2002 -> imem_addr=0x180, addr_err one pulse.
- Redirect EXC while FETCH waiting 3 cycles for imem_ready -> imem_addr unchanged until ready, response discarded, next request at 0x180, instr_valid never asserted for stale word.
- instr_ready held 0 for 5 cycles in HOLD -> instr/instr_pc stable, no imem_req, pc unchanged.
- Reset asserted during outstanding FETCH at 0x40 -> next cycle imem_req 0, pc=0, instr_valid 0.
